// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Control codes, FSM state and shift-kind types for the execute stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_kind_t;

  function automatic shift_kind_t shift_kind(input logic [3:0] code);
    case (code)
      ALU_SRL: return SH_SRL;
      ALU_SRA: return SH_SRA;
      default: return SH_SLL;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_shifter.sv
// ============================================================================
// Module : serial_shifter
// Brief  : Iterative 1-bit/cycle shifter; done flags a zero remaining count.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_shifter
  import alu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  shift_kind_t     kind,
  input  logic [XLEN-1:0] din,
  input  logic [SHW-1:0]  amt,
  input  logic            hold,
  output logic            done,
  output logic [XLEN-1:0] acc
);

  logic [XLEN-1:0] r_acc;
  logic [SHW-1:0]  r_cnt;
  shift_kind_t     r_kind;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_kind <= SH_SLL;
    end else if (load) begin
      r_acc  <= din;
      r_cnt  <= amt;
      r_kind <= kind;
    end else if (!hold && (r_cnt != '0)) begin
      case (r_kind)
        SH_SRL:  r_acc <= {1'b0, r_acc[XLEN-1:1]};
        SH_SRA:  r_acc <= {r_acc[XLEN-1], r_acc[XLEN-1:1]};
        default: r_acc <= {r_acc[XLEN-2:0], 1'b0};
      endcase
      r_cnt <= r_cnt - SHW'(1);
    end
  end

  assign done = (r_cnt == '0);
  assign acc  = r_acc;

endmodule

`default_nettype wire

// File: rtl/alu_exec_stage.sv
// ============================================================================
// Module : alu_exec_stage
// Brief  : Registered ALU execute stage with serial shifter and valid/ready.
//          Optional macro ALU_OVF_EN adds the registered signed-overflow port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_stage
  import alu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [4:0]      rd_out,
  output logic            illegal
`ifdef ALU_OVF_EN
  ,
  output logic            ovf
`endif
);

  state_t          r_state;
  state_t          w_next_state;
  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic [4:0]      r_rd;
  logic            r_illegal;
  logic [4:0]      r_rd_busy;

  logic            w_slot_free;
  logic            w_accept;
  logic            w_is_shift;
  logic            w_start_shift;
  logic            w_single_wr;
  logic            w_shift_wr;
  logic            w_hold;
  logic            w_done;
  logic            w_lt;
  logic            w_single_ill;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_single_res;
  logic [XLEN-1:0] w_acc;

  assign w_slot_free   = !r_out_valid || out_ready;
  assign w_accept      = in_valid && in_ready;
  assign w_shamt       = op_b[SHW-1:0];
  assign w_start_shift = w_accept && w_is_shift && (w_shamt != '0);
  assign w_single_wr   = w_accept && !w_start_shift;
  assign w_shift_wr    = (r_state == BUSY) && w_done && w_slot_free;

  assign w_sum  = op_a + op_b;
  assign w_diff = op_a - op_b;
  assign w_lt   = $signed(op_a) < $signed(op_b);

  // Unknown codes fall to default, so X/Z also retire as illegal.
  always_comb begin
    w_single_res = '0;
    w_single_ill = 1'b0;
    w_is_shift   = 1'b0;
    case (ctrl)
      ALU_AND: w_single_res = op_a & op_b;
      ALU_OR:  w_single_res = op_a | op_b;
      ALU_ADD: w_single_res = w_sum;
      ALU_SUB: w_single_res = w_diff;
      ALU_SLT: w_single_res = {{(XLEN-1){1'b0}}, w_lt};
      ALU_SLL, ALU_SRL, ALU_SRA: begin
        w_is_shift   = 1'b1;
        w_single_res = op_a;
      end
      default: w_single_ill = 1'b1;
    endcase
  end

`ifdef ALU_OVF_EN
  logic w_ovf;
  logic r_ovf;

  always_comb begin
    w_ovf = 1'b0;
    case (ctrl)
      ALU_ADD: w_ovf = (op_a[XLEN-1] == op_b[XLEN-1]) && (w_sum[XLEN-1] != op_a[XLEN-1]);
      ALU_SUB: w_ovf = (op_a[XLEN-1] != op_b[XLEN-1]) && (w_diff[XLEN-1] != op_a[XLEN-1]);
      default: w_ovf = 1'b0;
    endcase
  end
`endif

  serial_shifter #(
    .XLEN (XLEN)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_start_shift),
    .kind  (shift_kind(ctrl)),
    .din   (op_a),
    .amt   (w_shamt),
    .hold  (w_hold),
    .done  (w_done),
    .acc   (w_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start_shift) w_next_state = BUSY;
      BUSY:    if (w_shift_wr)    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == IDLE) && w_slot_free;
    w_hold   = (r_state != BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_busy <= '0;
    end else if (w_start_shift) begin
      r_rd_busy <= rd_in;
    end
  end

  // A new write always wins over a consume, keeping out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_rd        <= '0;
      r_illegal   <= 1'b0;
`ifdef ALU_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else if (w_single_wr) begin
      r_out_valid <= 1'b1;
      r_result    <= w_single_res;
      r_zero      <= (w_single_res == '0);
      r_rd        <= rd_in;
      r_illegal   <= w_single_ill;
`ifdef ALU_OVF_EN
      r_ovf       <= w_ovf;
`endif
    end else if (w_shift_wr) begin
      r_out_valid <= 1'b1;
      r_result    <= w_acc;
      r_zero      <= (w_acc == '0);
      r_rd        <= r_rd_busy;
      r_illegal   <= 1'b0;
`ifdef ALU_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign rd_out    = r_rd;
  assign illegal   = r_illegal;
`ifdef ALU_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
// ============================================================================
// Module : tb_alu_exec_stage
// Brief  : Randomised scoreboard bench for alu_exec_stage (ALU_OVF_EN aware).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_stage;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [4:0]      rd_out;
  logic            illegal;
`ifdef ALU_OVF_EN
  logic            ovf;
`endif

  alu_exec_stage #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd_in     (rd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .rd_out    (rd_out),
    .illegal   (illegal)
`ifdef ALU_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic [4:0]  rd;
    logic        ill;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;
  logic rand_rdy = 1'b0;

  // Reference: plain arithmetic on 64-bit signed values, shifts in one step.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd);
    exp_t   e;
    longint sa;
    longint sb;
    longint s;
    int     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    e.rd  = rd;
    e.ill = 1'b0;
    e.ovf = 1'b0;
    case (c)
      ALU_AND: e.res = a & b;
      ALU_OR:  e.res = a | b;
      ALU_ADD: begin
        e.res = a + b;
        s     = sa + sb;
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_SUB: begin
        e.res = a - b;
        s     = sa - sb;
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_SLT: e.res = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLL: e.res = a << sh;
      ALU_SRL: e.res = a >> sh;
      ALU_SRA: e.res = $signed(a) >>> sh;
      default: begin
        e.res = '0;
        e.ill = 1'b1;
      end
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int waited);
    ctrl     = c;
    op_a     = a;
    op_b     = b;
    rd_in    = rd;
    in_valid = 1'b1;
    waited   = 0;
    forever begin
      @(negedge clk);
      waited++;
      if (in_ready) break;
      if (waited > 200) begin
        checks++;
        $display("FAIL accept_timeout: in_ready 0 for %0d cycles, expected 1", waited);
        break;
      end
    end
    if (in_ready) sbq.push_back(model(c, a, b, rd));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every presented result must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got result 0x%0h, expected no output", result);
        end else begin
          e = sbq[0];
          chk("result", result, e.res);
          chk("zero", zero, e.zero);
          chk("rd_out", rd_out, e.rd);
          chk("illegal", illegal, e.ill);
`ifdef ALU_OVF_EN
          chk("ovf", ovf, e.ovf);
`endif
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          lat;
    logic        seen;
    logic [3:0]  codes[8];
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    codes = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ctrl      = '0;
    op_a      = '0;
    op_b      = '0;
    rd_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_rd_out", rd_out, 0);
    chk("rst_illegal", illegal, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    issue(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd1, w);
    chk("add_wait", w, 1);
    issue(ALU_SUB, 32'd5, 32'd5, 5'd2, w);
    chk("sub_wait", w, 1);
    issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd3, w);
    issue(ALU_SRA, 32'h8000_1234, 32'hFFFF_FFE0, 5'd4, w);
    chk("shamt0_wait", w, 1);
    issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd5, w);
    issue(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd6, w);

    // SRA shamt=4: in_ready low for shamt+1 cycles, then the result appears.
    ctrl     = ALU_SRA;
    op_a     = 32'h8000_0000;
    op_b     = 32'd4;
    rd_in    = 5'd9;
    in_valid = 1'b1;
    @(negedge clk);
    chk("sra_accept", in_ready, 1);
    sbq.push_back(model(ALU_SRA, 32'h8000_0000, 32'd4, 5'd9));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) seen = 1'b1;
      lat++;
    end
    chk("sra_latency", lat, 5);
    chk("sra_busy_in_ready", seen, 0);
    chk("sra_done_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    issue(ALU_ADD, 32'd10, 32'd20, 5'd7, w);
    ctrl     = ALU_SUB;
    op_a     = 32'h8000_0000;
    op_b     = 32'd1;
    rd_in    = 5'd8;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(ALU_SUB, 32'h8000_0000, 32'd1, 5'd8, w);
    chk("bp_accept_wait", w, 1);
    for (int i = 0; i < 4; i++) begin
      issue(ALU_OR, $urandom, $urandom, 5'(i + 10), w);
      chk("throughput_wait", w, 1);
    end

    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      c = ($urandom_range(0, 9) == 0) ? 4'(8 + $urandom_range(0, 7)) : codes[$urandom_range(0, 7)];
      case ($urandom_range(0, 4))
        0:       a = 32'h7FFF_FFFF;
        1:       a = 32'h8000_0000;
        2:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      b = $urandom;
      if ($urandom_range(0, 2) == 0) b[4:0] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) b = a;
      issue(c, a, b, 5'($urandom_range(0, 31)), w);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    lat = 0;
    while ((sbq.size() != 0 || out_valid) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("drain_pending", sbq.size(), 0);
    @(posedge clk);
    #1;

    // Reset while an SLL shamt=10 is in flight: nothing may retire.
    ctrl     = ALU_SLL;
    op_a     = 32'd1;
    op_b     = 32'd10;
    rd_in    = 5'd31;
    in_valid = 1'b1;
    @(negedge clk);
    chk("sll_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", seen, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
